// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster generator: pixel/line counters, blank, active-low syncs, frame/vblank strobes.
// Optional macro VGA_SYNC_ALIGN_EN delays hs/vs by one clock to line up with a registered renderer.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       vblank_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_LINE = 10'(V_VISIBLE);
  // Decode bounds are 11 bits wide so an end bound of 1024 does not wrap to 0.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  draw_x_reg, draw_y_reg;
  logic [9:0]  h_next, v_next;
  logic [10:0] h_ext, v_ext;
  logic        blank_reg, hs_reg, vs_reg, frame_start_reg, vblank_start_reg;
  logic        blank_next, hs_next, vs_next, frame_start_next, vblank_start_next;

  always_comb begin
    h_next = draw_x_reg + 10'd1;
    v_next = draw_y_reg;
    if (draw_x_reg == H_LAST) begin
      h_next = '0;
      v_next = (draw_y_reg == V_LAST) ? '0 : draw_y_reg + 10'd1;
    end
  end

  // Outputs decode the next counter value so they register alongside it.
  always_comb begin
    h_ext             = {1'b0, h_next};
    v_ext             = {1'b0, v_next};
    blank_next        = (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
    hs_next           = !((h_ext >= HS_START) && (h_ext < HS_END));
    vs_next           = !((v_ext >= VS_START) && (v_ext < VS_END));
    frame_start_next  = (h_next == '0) && (v_next == '0);
    vblank_start_next = (h_next == '0) && (v_next == V_VIS_LINE);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      draw_x_reg       <= '0;
      draw_y_reg       <= '0;
      blank_reg        <= 1'b1;
      hs_reg           <= 1'b1;
      vs_reg           <= 1'b1;
      frame_start_reg  <= 1'b0;
      vblank_start_reg <= 1'b0;
    end else begin
      draw_x_reg       <= h_next;
      draw_y_reg       <= v_next;
      blank_reg        <= blank_next;
      hs_reg           <= hs_next;
      vs_reg           <= vs_next;
      frame_start_reg  <= frame_start_next;
      vblank_start_reg <= vblank_start_next;
    end
  end

  assign DrawX        = draw_x_reg;
  assign DrawY        = draw_y_reg;
  assign blank        = blank_reg;
  assign frame_start  = frame_start_reg;
  assign vblank_start = vblank_start_reg;

`ifdef VGA_SYNC_ALIGN_EN
  logic hs_align_reg, vs_align_reg;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hs_align_reg <= 1'b1;
      vs_align_reg <= 1'b1;
    end else begin
      hs_align_reg <= hs_reg;
      vs_align_reg <= vs_reg;
    end
  end

  assign hs = hs_align_reg;
  assign vs = vs_align_reg;
`else
  assign hs = hs_reg;
  assign vs = vs_reg;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output path. It drives the DrawX/DrawY pixel coordinates and the active-high `blank` (display-enable) qualifier consumed by the sprite and palette renderers, plus the hs/vs sync pulses that go to the VGA connector. All outputs are registered and run on the 25 MHz `vga_clk` pixel clock. It also emits one-cycle frame and vertical-blank strobes that game logic uses to latch per-frame state.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width (clocks)
- `H_BACK`, 48, horizontal back porch (clocks)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `vga_clk`  in  1  pixel clock; the only clock
- `reset`  in  1  asynchronous, active-high reset
- `DrawX`  out  10  current horizontal pixel index, 0..H_TOTAL-1
- `DrawY`  out  10  current line index, 0..V_TOTAL-1
- `blank`  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE); 0 = blanking
- `hs`  out  1  horizontal sync, active-low
- `vs`  out  1  vertical sync, active-low
- `frame_start`  out  1  one-cycle strobe at (DrawX,DrawY)=(0,0)
- `vblank_start`  out  1  one-cycle strobe at (0,V_VISIBLE)

## Operation
- H_TOTAL = sum of the H_* parameters (800). V_TOTAL = sum of the V_* parameters (525). Both must be ≤1024; the checked-in defaults satisfy this, and the generator does not range-check them.
- The horizontal counter increments every clock. At H_TOTAL-1 it wraps to 0 and the vertical counter advances.
- The vertical counter wraps from V_TOTAL-1 to 0 when the horizontal counter also wraps.
- Each output is a register loaded from a decode of the next counter value. As a result, `blank`, `hs`, `vs` and the strobes always describe the DrawX/DrawY value present in the same cycle.
- `hs` = 0 iff H_VISIBLE+H_FRONT ≤ DrawX < H_VISIBLE+H_FRONT+H_SYNC (656..751).
- `vs` = 0 iff V_VISIBLE+V_FRONT ≤ DrawY < V_VISIBLE+V_FRONT+V_SYNC (490..491).
- There is no enable or stall. The raster runs freely whenever `reset` is low.
- Reset values: DrawX=0, DrawY=0, blank=1, hs=1, vs=1, frame_start=0, vblank_start=0.
- Reset is honoured mid-frame: all outputs go to their reset values immediately, without waiting for a clock edge.
- After reset releases, counting resumes from (0,0).
- The first `frame_start` after reset occurs at the next wrap to (0,0), H_TOTAL·V_TOTAL clocks after release. No pulse is issued for the reset-entered (0,0).

## Timing
- Line period: 800 clocks. Frame period: 420000 clocks.
- Visible line: DrawX 0..639 with `blank`=1. `blank` falls in the cycle DrawX becomes 640 and rises in the cycle DrawX becomes 0 on a visible line.
- `hs` low for exactly 96 consecutive clocks per line, on every line including vertical blanking.
- `vs` low for exactly 2 lines (1600 clocks). It falls and rises in the cycles where DrawX=0.
- `frame_start` and `vblank_start` are each high for exactly one clock per frame.
- A downstream renderer that samples DrawX/DrawY/`blank` on posedge `vga_clk` produces its RGB one cycle later (see Configuration).

## Configuration
- `VGA_SYNC_ALIGN_EN` defined: `hs` and `vs` pass through one additional register stage, so they lag DrawX/DrawY by one clock and align with the registered RGB output of the renderer. The extra stage resets to 1. DrawX, DrawY, `blank` and the strobes are unchanged.
- Not defined: `hs` and `vs` are aligned with DrawX/DrawY as described in Operation.

## Test plan
- Assert `reset`, then release it: outputs are DrawX=0, DrawY=0, blank=1, hs=1, vs=1 and both strobes 0. The next cycle shows DrawX=1.
- Line sweep, macro off: `hs` goes 0 in the cycle DrawX=656 and returns to 1 at DrawX=752, giving 96 low cycles. `blank` is 0 for DrawX 640..799.
- Line wrap: the cycle after (799,5) shows (0,6). The cycle after (799,524) shows (0,0), with `frame_start`=1 for that single cycle.
- Vertical window: `vs`=0 exactly while DrawY is 490..491. `vblank_start`=1 only at (0,480). `blank`=0 for every pixel with DrawY ≥ 480.
- Assert `reset` asynchronously at (300,200) mid-clock: outputs reach their reset values before the next edge. After release, counting restarts from (0,0), and the first `frame_start` arrives 420000 clocks later.
- With `VGA_SYNC_ALIGN_EN` defined: `hs` falls in the cycle DrawX=657 and `vs` falls at (1,490). `blank` timing is identical to the macro-off case.
